// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words
// and compares them against the values this image was built with.
module sysid_check_ctrl #(
   parameter logic [31:0] EXP_ID     = 32'd807520620,
   parameter logic [31:0] EXP_TS     = 32'd1321024492,
   parameter int unsigned RD_LATENCY = 0,
   parameter int unsigned TIMEOUT    = 255,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
   localparam bit          HAS_LAT  = (RD_LATENCY != 0);
   localparam logic [2:0]  LAT_LAST = 3'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_ID  = 3'd1,
      S_LAT_ID = 3'd2,
      S_RD_TS  = 3'd3,
      S_LAT_TS = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic          auto_q, auto_d;
   logic          avm_read_q, avm_read_d;
   logic          avm_address_q, avm_address_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          id_match_q, id_match_d;
   logic          ts_match_q, ts_match_d;
   logic          timeout_err_q, timeout_err_d;
   logic [31:0]   id_value_q, id_value_d;
   logic [31:0]   ts_value_q, ts_value_d;
   logic [2:0]    lat_cnt_q, lat_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [TW-1:0] tmo_inc_s;
   logic          launch_s;

   // Next-state and output computation for the readout sequence
   always_comb begin
      state_d       = state_q;
      auto_d        = 1'b0;
      avm_read_d    = avm_read_q;
      avm_address_d = avm_address_q;
      busy_d        = busy_q;
      done_d        = done_q;
      id_match_d    = id_match_q;
      ts_match_d    = ts_match_q;
      timeout_err_d = timeout_err_q;
      id_value_d    = id_value_q;
      ts_value_d    = ts_value_q;
      lat_cnt_d     = lat_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      tmo_inc_s     = tmo_cnt_q + TW'(1);
      launch_s      = (start == 1'b1) || (auto_q == 1'b1);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (launch_s) begin
               state_d       = S_RD_ID;
               avm_read_d    = 1'b1;
               avm_address_d = 1'b0;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               id_match_d    = 1'b0;
               ts_match_d    = 1'b0;
               timeout_err_d = 1'b0;
               lat_cnt_d     = 3'd0;
               tmo_cnt_d     = '0;
            end else begin
               state_d = state_q;
            end
         end
         S_RD_ID, S_RD_TS: begin
            if (!avm_waitrequest) begin
               tmo_cnt_d     = '0;
               lat_cnt_d     = 3'd0;
               avm_address_d = 1'b1;
               if (HAS_LAT) begin
                  avm_read_d = 1'b0;
                  state_d    = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
               end else if (state_q == S_RD_ID) begin
                  id_value_d = avm_readdata;
                  state_d    = S_RD_TS;
               end else begin
                  ts_value_d = avm_readdata;
                  avm_read_d = 1'b0;
                  state_d    = S_CHECK;
               end
            end else if (tmo_inc_s == TMO_MAX) begin
               // Stall limit hit: withdraw the read and report, no capture
               avm_read_d    = 1'b0;
               timeout_err_d = 1'b1;
               busy_d        = 1'b0;
               tmo_cnt_d     = '0;
               state_d       = S_DONE;
            end else begin
               tmo_cnt_d = tmo_inc_s;
            end
         end
         S_LAT_ID: begin
            if (lat_cnt_q == LAT_LAST) begin
               id_value_d = avm_readdata;
               avm_read_d = 1'b1;
               state_d    = S_RD_TS;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         S_LAT_TS: begin
            if (lat_cnt_q == LAT_LAST) begin
               ts_value_d = avm_readdata;
               state_d    = S_CHECK;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         S_CHECK: begin
            id_match_d = (id_value_q == EXP_ID);
            ts_match_d = (ts_value_q == EXP_TS);
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         auto_q        <= AUTO_START;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_match_q    <= 1'b0;
         ts_match_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         id_value_q    <= 32'd0;
         ts_value_q    <= 32'd0;
         lat_cnt_q     <= 3'd0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         auto_q        <= auto_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_match_q    <= id_match_d;
         ts_match_q    <= ts_match_d;
         timeout_err_q <= timeout_err_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
         lat_cnt_q     <= lat_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_match    = id_match_q;
   assign ts_match    = ts_match_q;
   assign timeout_err = timeout_err_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Randomized bench for sysid_check_ctrl: three configurations driven by a
// transaction-level slave model with expected timing derived from stall counts.
module tb_sysid_check_ctrl;

   localparam logic [31:0] EXP_ID = 32'd807520620;
   localparam logic [31:0] EXP_TS = 32'd1321024492;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst_n_s, start_s, wr_s;
   logic [2:0]  rd_s, addr_s, busy_s, done_s, idm_s, tsm_s, terr_s;
   logic [31:0] rdata_s [3];
   logic [31:0] idv_s [3];
   logic [31:0] tsv_s [3];

   int total_cnt = 0;
   int bad_cnt   = 0;
   logic [31:0] m_id [3];
   logic [31:0] m_ts [3];
   int lat_of [3] = '{0, 0, 2};
   int tmo_of [3] = '{255, 4, 255};

   sysid_check_ctrl u_dut0 (
      .clk(clk), .reset_n(rst_n_s[0]), .start(start_s[0]),
      .avm_address(addr_s[0]), .avm_read(rd_s[0]), .avm_waitrequest(wr_s[0]),
      .avm_readdata(rdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .id_match(idm_s[0]), .ts_match(tsm_s[0]), .timeout_err(terr_s[0]),
      .id_value(idv_s[0]), .ts_value(tsv_s[0]));

   sysid_check_ctrl #(.TIMEOUT(4)) u_dut1 (
      .clk(clk), .reset_n(rst_n_s[1]), .start(start_s[1]),
      .avm_address(addr_s[1]), .avm_read(rd_s[1]), .avm_waitrequest(wr_s[1]),
      .avm_readdata(rdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .id_match(idm_s[1]), .ts_match(tsm_s[1]), .timeout_err(terr_s[1]),
      .id_value(idv_s[1]), .ts_value(tsv_s[1]));

   sysid_check_ctrl #(.RD_LATENCY(2)) u_dut2 (
      .clk(clk), .reset_n(rst_n_s[2]), .start(start_s[2]),
      .avm_address(addr_s[2]), .avm_read(rd_s[2]), .avm_waitrequest(wr_s[2]),
      .avm_readdata(rdata_s[2]), .busy(busy_s[2]), .done(done_s[2]),
      .id_match(idm_s[2]), .ts_match(tsm_s[2]), .timeout_err(terr_s[2]),
      .id_value(idv_s[2]), .ts_value(tsv_s[2]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic check_reset(input int k);
      check_val("rst_ctl", 32'({rd_s[k], addr_s[k], busy_s[k], done_s[k], idm_s[k], tsm_s[k], terr_s[k]}), 32'd0);
      check_val("rst_idv", idv_s[k], 32'd0);
      check_val("rst_tsv", tsv_s[k], 32'd0);
      m_id[k] = 32'd0;
      m_ts[k] = 32'd0;
   endtask

   // One sequence: launch (start pulse or reset release), act as the slave,
   // and compare timing and results against the model.
   task automatic run_seq(input int k, input bit by_start, input int s0, input int s1,
                          input bit hang, input logic [31:0] d0, input logic [31:0] d1,
                          input bit start_busy, input bit rst_mid);
      int lat = lat_of[k];
      int tmo = tmo_of[k];
      int t_end;
      int wi = 0;
      int used = 0;
      int pend = 0;
      int lw = 0;
      bit stalled = 1'b0;
      logic [31:0] dw [2];
      dw[0] = d0;
      dw[1] = d1;
      t_end = hang ? (1 + s0 + lat + tmo) : (3 + s0 + s1 + 2 * lat);
      @(negedge clk);
      if (by_start) start_s[k] = 1'b1;
      else          rst_n_s[k] = 1'b1;
      for (int i = 1; i <= t_end; i++) begin
         @(negedge clk);
         start_s[k] = start_busy && (i == 2);
         check_val("busy_done", 32'({busy_s[k], done_s[k]}), 32'd2);
         if (rst_mid && wi == 1 && rd_s[k] && addr_s[k]) begin
            rst_n_s[k] = 1'b0;
            #1;
            check_reset(k);
            return;
         end
         if (pend > 0) begin
            pend--;
            check_val("rd_lat", 32'(rd_s[k]), 32'd0);
            rdata_s[k] = (pend == 0) ? dw[lw] : $urandom;
            wr_s[k] = 1'($urandom_range(0, 1));
         end else if (rd_s[k]) begin
            check_val("addr", 32'(addr_s[k]), (wi == 1) ? 32'd1 : 32'd0);
            if ((wi == 0 && used < s0) || (wi == 1 && (hang || used < s1))) begin
               wr_s[k] = 1'b1;
               used++;
               stalled = 1'b1;
               rdata_s[k] = $urandom;
            end else begin
               wr_s[k] = 1'b0;
               stalled = 1'b0;
               used = 0;
               if (lat == 0) begin
                  rdata_s[k] = dw[wi & 1];
               end else begin
                  rdata_s[k] = $urandom;
                  pend = lat;
                  lw = wi & 1;
               end
               wi++;
            end
         end else begin
            if (stalled) check_val("rd_hold", 32'(rd_s[k]), 32'd1);
            stalled = 1'b0;
            wr_s[k] = 1'($urandom_range(0, 1));
            rdata_s[k] = $urandom;
         end
      end
      @(negedge clk);
      wr_s[k] = 1'b0;
      check_val("rd_end", 32'(rd_s[k]), 32'd0);
      if (hang) begin
         m_id[k] = d0;
         check_val("tmo_busy_done", 32'({busy_s[k], done_s[k]}), 32'd0);
         check_val("tmo_err", 32'(terr_s[k]), 32'd1);
         check_val("tmo_match", 32'({idm_s[k], tsm_s[k]}), 32'd0);
      end else begin
         m_id[k] = d0;
         m_ts[k] = d1;
         check_val("end_busy_done", 32'({busy_s[k], done_s[k]}), 32'd1);
         check_val("end_err", 32'(terr_s[k]), 32'd0);
         check_val("id_match", 32'(idm_s[k]), (d0 == EXP_ID) ? 32'd1 : 32'd0);
         check_val("ts_match", 32'(tsm_s[k]), (d1 == EXP_TS) ? 32'd1 : 32'd0);
      end
      check_val("id_value", idv_s[k], m_id[k]);
      check_val("ts_value", tsv_s[k], m_ts[k]);
   endtask

   initial begin
      logic [31:0] rd0, rd1;
      rst_n_s = 3'b000;
      start_s = 3'b000;
      wr_s    = 3'b000;
      for (int k = 0; k < 3; k++) rdata_s[k] = 32'd0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) check_reset(k);

      for (int k = 0; k < 3; k++) begin
         run_seq(k, 1'b0, 0, 0, 1'b0, EXP_ID, EXP_TS, 1'b0, 1'b0);
         run_seq(k, 1'b1, 0, 0, 1'b0, EXP_ID, 32'h0000_0000, 1'b0, 1'b0);
         run_seq(k, 1'b1, 3, 3, 1'b0, EXP_ID, EXP_TS, 1'b0, 1'b0);
         run_seq(k, 1'b1, 1, 2, 1'b0, EXP_ID, EXP_TS, 1'b1, 1'b0);
         for (int r = 0; r < 8; r++) begin
            rd0 = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            rd1 = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            run_seq(k, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0,
                    rd0, rd1, 1'($urandom_range(0, 1)), 1'b0);
         end
         if (k == 1) begin
            run_seq(k, 1'b1, 1, 0, 1'b1, 32'h1234_5678, EXP_TS, 1'b0, 1'b0);
            run_seq(k, 1'b1, 0, 1, 1'b0, EXP_ID, EXP_TS, 1'b0, 1'b0);
         end
         run_seq(k, 1'b1, 0, 0, 1'b0, EXP_ID, EXP_TS, 1'b0, 1'b1);
         run_seq(k, 1'b0, 2, 1, 1'b0, EXP_ID, EXP_TS, 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
